// File: rtl/axi_burst_writer.sv
// AXI3 write-channel master: one INCR burst per command, AW -> W beats -> B,
// with a single burst in flight at a time.
module axi_burst_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int ID_VALUE   = 0,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    // client data stream
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    // completion
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    // AW channel
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [LEN_WIDTH-1:0]    awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    // W channel
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    // B channel
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int SIZE = $clog2(DATA_WIDTH / 8);

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [LEN_WIDTH-1:0]  awlen_q, awlen_d;
    logic                  done_valid_q, done_valid_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic                  in_data;
    logic                  beat;
    logic                  last_beat;

    // bid is only carried for bus completeness; responses are in order
    logic unused_bid;
    assign unused_bid = ^bid;

    assign in_data   = (state_q == S_DATA);
    assign last_beat = (cnt_q == awlen_q);
    assign beat      = in_data && wr_valid && wready;

    // Constant AW attributes and state-decoded handshakes
    assign awid       = ID_WIDTH'(ID_VALUE);
    assign awsize     = 3'(SIZE);
    assign awburst    = 2'b01;
    assign awaddr     = awaddr_q;
    assign awlen      = awlen_q;
    assign awvalid    = awvalid_q;
    assign cmd_ready  = (state_q == S_IDLE);
    assign wdata      = wr_data;
    assign wstrb      = '1;
    assign wvalid     = in_data && wr_valid;
    assign wr_ready   = in_data && wready;
    assign wlast      = in_data && last_beat;
    assign bready     = (state_q == S_RESP);
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;

    // Next-state logic: serialize AW, W beats and B for one burst
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    awaddr_d  = cmd_addr;
                    awlen_d   = cmd_len;
                    cnt_d     = '0;
                    awvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                // counter parks on awlen at the final beat, so len=15 never wraps
                if (beat) begin
                    if (last_beat) state_d = S_RESP;
                    else           cnt_d   = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bvalid) begin
                    done_resp_d  = bresp;
                    done_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset abandons any burst
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            done_valid_q <= 1'b0;
            done_resp_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
        end
    end

endmodule
